// File: rtl/icache_2way.sv
// Read-only 2-way set-associative instruction cache with 16-byte lines and per-set LRU.
// Define ICACHE_PERF_CNT_EN to add the hit_cnt/miss_cnt performance counters.
module icache_2way #(
    parameter int INDEX_WIDTH = 8,
    parameter int TAG_WIDTH   = 20
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   valid,
    input  logic                   op,
    input  logic [INDEX_WIDTH-1:0] index,
    input  logic [TAG_WIDTH-1:0]   tag,
    input  logic [3:0]             offset,
    output logic                   addr_ok,
    output logic                   data_ok,
    output logic [31:0]            rdata,
    output logic                   rd_req,
    output logic [2:0]             rd_type,
    output logic [31:0]            rd_addr,
    input  logic                   rd_rdy,
    input  logic                   ret_valid,
    input  logic                   ret_last,
    input  logic [31:0]            ret_data
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]            hit_cnt,
    output logic [31:0]            miss_cnt
`endif
);

    localparam int SETS = 1 << INDEX_WIDTH;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOOKUP  = 3'd1;
    localparam logic [2:0] S_MISS    = 3'd2;
    localparam logic [2:0] S_REFILL  = 3'd3;
    localparam logic [2:0] S_RESPOND = 3'd4;

    if (TAG_WIDTH + INDEX_WIDTH + 4 != 32) begin : g_bad_widths
        $error("icache_2way: TAG_WIDTH + INDEX_WIDTH + 4 must equal 32");
    end

    logic [2:0]             state;
    logic [TAG_WIDTH-1:0]   req_tag;
    logic [INDEX_WIDTH-1:0] req_index;
    logic [1:0]             req_word;

    logic [SETS-1:0]        vld_w0;
    logic [SETS-1:0]        vld_w1;
    logic [SETS-1:0]        lru;
    logic [TAG_WIDTH-1:0]   tag_ram  [2][SETS];
    logic [31:0]            data_ram [2][SETS][4];

    logic                   victim;
    logic [1:0]             cnt;
    logic [31:0]            line_buf [4];
    logic [31:0]            resp_word;
    logic [31:0]            last_rdata;

    logic                   hit0;
    logic                   hit1;
    logic                   hit_way;
    logic                   lookup_hit;
    logic                   lookup_miss;
    logic                   accept;
    logic                   victim_sel;
    logic [31:0]            hit_word;
    logic                   unused_offset_bits;

    assign unused_offset_bits = ^offset[1:0];

    assign hit0        = vld_w0[req_index] && (tag_ram[0][req_index] == req_tag);
    assign hit1        = vld_w1[req_index] && (tag_ram[1][req_index] == req_tag);
    assign hit_way     = hit1;
    assign lookup_hit  = (state == S_LOOKUP) && (hit0 || hit1);
    assign lookup_miss = (state == S_LOOKUP) && !(hit0 || hit1);
    assign hit_word    = data_ram[hit_way][req_index][req_word];

    // Invalid ways fill first (way0 before way1); otherwise LRU names the victim.
    assign victim_sel = !vld_w0[req_index] ? 1'b0 :
                        !vld_w1[req_index] ? 1'b1 : lru[req_index];

    assign addr_ok = !op && ((state == S_IDLE) || lookup_hit);
    assign accept  = valid && addr_ok;
    assign data_ok = lookup_hit || (state == S_RESPOND);
    assign rdata   = lookup_hit            ? hit_word  :
                     (state == S_RESPOND)  ? resp_word : last_rdata;

    assign rd_req  = (state == S_MISS);
    assign rd_type = 3'b100;
    assign rd_addr = {req_tag, req_index, 4'b0000};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            req_tag    <= '0;
            req_index  <= '0;
            req_word   <= '0;
            vld_w0     <= '0;
            vld_w1     <= '0;
            lru        <= '0;
            victim     <= 1'b0;
            cnt        <= 2'd0;
            last_rdata <= '0;
        end else begin
            if (data_ok) begin
                last_rdata <= rdata;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        req_tag   <= tag;
                        req_index <= index;
                        req_word  <= offset[3:2];
                        state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (lookup_hit) begin
                        lru[req_index] <= ~hit_way;
                        if (accept) begin
                            req_tag   <= tag;
                            req_index <= index;
                            req_word  <= offset[3:2];
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        victim <= victim_sel;
                        state  <= S_MISS;
                    end
                end
                S_MISS: begin
                    if (rd_rdy) begin
                        cnt   <= 2'd0;
                        state <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (ret_valid) begin
                        cnt <= cnt + 2'd1;
                        if (ret_last) begin
                            if (victim) vld_w1[req_index] <= 1'b1;
                            else        vld_w0[req_index] <= 1'b1;
                            lru[req_index] <= ~victim;
                            cnt            <= 2'd0;
                            state          <= S_RESPOND;
                        end
                    end
                end
                S_RESPOND: state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    // Arrays and refill staging carry no reset; valid bits qualify their contents.
    always_ff @(posedge clk) begin
        if ((state == S_REFILL) && ret_valid) begin
            line_buf[cnt] <= ret_data;
            if (cnt == req_word) begin
                resp_word <= ret_data;
            end
            if (ret_last) begin
                tag_ram[victim][req_index] <= req_tag;
                for (int w = 0; w < 4; w++) begin
                    data_ram[victim][req_index][w] <= (2'(w) == cnt) ? ret_data : line_buf[w];
                end
            end
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (lookup_hit)  hit_cnt  <= hit_cnt + 32'd1;
            if (lookup_miss) miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_2way.sv
// Bench for icache_2way: directed scenarios plus randomized reads against an MRU/LRU list model.
// Build with ICACHE_PERF_CNT_EN defined to also cover the performance counters.
module tb_icache_2way;

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid;
    logic        op;
    logic [7:0]  index;
    logic [19:0] tag;
    logic [3:0]  offset;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        rd_req;
    logic [2:0]  rd_type;
    logic [31:0] rd_addr;
    logic        rd_rdy;
    logic        ret_valid;
    logic        ret_last;
    logic [31:0] ret_data;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int checks = 0;
    int errors = 0;

    icache_2way #(.INDEX_WIDTH(8), .TAG_WIDTH(20)) dut (
        .clk(clk), .resetn(resetn), .valid(valid), .op(op),
        .index(index), .tag(tag), .offset(offset),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data)
`ifdef ICACHE_PERF_CNT_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference: per set, an MRU/LRU ordered list of at most two resident tags.
    logic [19:0] m_mru [256];
    logic [19:0] m_lru [256];
    int          m_cnt [256];

    function automatic void model_reset();
        for (int i = 0; i < 256; i++) m_cnt[i] = 0;
    endfunction

    function automatic bit model_access(input logic [31:0] a);
        int          s;
        logic [19:0] t;
        s = int'(a[11:4]);
        t = a[31:12];
        if (m_cnt[s] >= 1 && m_mru[s] == t) return 1'b1;
        if (m_cnt[s] == 2 && m_lru[s] == t) begin
            m_lru[s] = m_mru[s];
            m_mru[s] = t;
            return 1'b1;
        end
        if (m_cnt[s] >= 1) m_lru[s] = m_mru[s];
        m_mru[s] = t;
        if (m_cnt[s] < 2) m_cnt[s] = m_cnt[s] + 1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        if (a[31:4] == 28'hBFC0000) begin
            w = {30'd0, a[3:2]} + 32'd1;
            return 32'h11 * w;
        end
        return ({a[31:2], 2'b00} * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    task automatic apply_reset();
        valid = 0; op = 0; rd_rdy = 0; ret_valid = 0; ret_last = 0; ret_data = '0;
        resetn = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn = 1;
        model_reset();
        @(posedge clk); #1;
    endtask

    // One read, serving any refill as the memory side. abort_beat >= 0 resets mid-refill.
    task automatic do_read(input logic [31:0] a, input int rdy_delay, input int abort_beat,
                           input string name, output bit hit_seen);
        bit          exp_hit;
        logic [31:0] exp_word;
        int          n;
        hit_seen = 0;
        exp_word = mem_word(a);
        exp_hit  = model_access(a);
        valid = 1; op = 0; tag = a[31:12]; index = a[11:4]; offset = a[3:0];
        n = 0;
        @(negedge clk);
        while (!addr_ok && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: addr_ok=%b, required 1 within 20 cycles", name, addr_ok);
            valid = 0;
            return;
        end
        @(posedge clk); #1;
        valid = 0;
        @(negedge clk);
        hit_seen = data_ok;
        checks++;
        if (hit_seen !== exp_hit) begin
            errors++;
            $display("FAIL %s hit_miss addr=%h: hit=%b, required %b", name, a, hit_seen, exp_hit);
        end
        if (data_ok) begin
            checks++;
            if (rdata !== exp_word || rd_req !== 1'b0) begin
                errors++;
                $display("FAIL %s hit_data: rdata=%h rd_req=%b, required %h and 0", name, rdata, rd_req, exp_word);
            end
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
            for (int d = 0; d <= rdy_delay; d++) begin
                if (d == rdy_delay) rd_rdy = 1;
                @(negedge clk);
                checks++;
                if (rd_req !== 1'b1 || rd_addr !== {a[31:4], 4'b0000} || rd_type !== 3'b100) begin
                    errors++;
                    $display("FAIL %s miss_req: rd_req=%b rd_addr=%h rd_type=%b, required 1 %h 100",
                             name, rd_req, rd_addr, rd_type, {a[31:4], 4'b0000});
                end
                @(posedge clk); #1;
                rd_rdy = 0;
            end
            for (int b = 0; b < 4; b++) begin
                if (b == abort_beat) begin
                    ret_valid = 0; ret_last = 0;
                    resetn = 0;
                    #1;
                    checks++;
                    if (rd_req !== 1'b0 || data_ok !== 1'b0 || addr_ok !== 1'b1 || rdata !== 32'd0) begin
                        errors++;
                        $display("FAIL %s reset_mid_refill: rd_req=%b data_ok=%b addr_ok=%b rdata=%h, required 0 0 1 0",
                                 name, rd_req, data_ok, addr_ok, rdata);
                    end
                    @(posedge clk); #1;
                    resetn = 1;
                    model_reset();
                    @(posedge clk); #1;
                    return;
                end
                ret_valid = 1;
                ret_last  = (b == 3);
                ret_data  = mem_word({a[31:4], 2'(b), 2'b00});
                @(negedge clk);
                checks++;
                if (data_ok !== 1'b0) begin
                    errors++;
                    $display("FAIL %s early_data_ok beat %0d: data_ok=%b, required 0", name, b, data_ok);
                end
                @(posedge clk); #1;
            end
            ret_valid = 0; ret_last = 0;
            @(negedge clk);
            checks++;
            if (data_ok !== 1'b1 || rdata !== exp_word) begin
                errors++;
                $display("FAIL %s refill_resp: data_ok=%b rdata=%h, required 1 %h", name, data_ok, rdata, exp_word);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (data_ok !== 1'b0 || rdata !== exp_word) begin
            errors++;
            $display("FAIL %s rdata_hold: data_ok=%b rdata=%h, required 0 %h", name, data_ok, rdata, exp_word);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        valid = 0; op = 0; rd_rdy = 0; ret_valid = 0; ret_last = 0; ret_data = '0;
        tag = '0; index = '0; offset = '0;
        resetn = 0;
        #1;
        checks++;
        if (addr_ok !== 1'b1 || data_ok !== 1'b0 || rdata !== 32'd0 || rd_req !== 1'b0 || rd_addr !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: addr_ok=%b data_ok=%b rdata=%h rd_req=%b rd_addr=%h, required 1 0 0 0 0",
                     addr_ok, data_ok, rdata, rd_req, rd_addr);
        end
`ifdef ICACHE_PERF_CNT_EN
        checks++;
        if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_perf: hit_cnt=%0d miss_cnt=%0d, required 0 0", hit_cnt, miss_cnt);
        end
`endif
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn = 1;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_cold_miss_hit();
        bit h;
        apply_reset();
        do_read(32'hBFC00000, 2, -1, "cold_miss", h);
        checks++;
        if (h !== 1'b0) begin
            errors++;
            $display("FAIL cold_miss_kind: hit=%b, required 0", h);
        end
        do_read(32'hBFC00008, 0, -1, "warm_hit", h);
        checks++;
        if (h !== 1'b1) begin
            errors++;
            $display("FAIL warm_hit_kind: hit=%b, required 1", h);
        end
`ifdef ICACHE_PERF_CNT_EN
        checks++;
        if (hit_cnt !== 32'd1 || miss_cnt !== 32'd1) begin
            errors++;
            $display("FAIL perf_counts: hit_cnt=%0d miss_cnt=%0d, required 1 1", hit_cnt, miss_cnt);
        end
`endif
    endtask

    task automatic test_critical_word();
        bit h;
        do_read(32'h1000000C, 0, -1, "critical_word", h);
        checks++;
        if (h !== 1'b0) begin
            errors++;
            $display("FAIL critical_word_kind: hit=%b, required 0", h);
        end
    endtask

    task automatic test_back_to_back();
        bit          h;
        logic [31:0] base;
        base = 32'h00400000;
        do_read(base, 1, -1, "b2b_fill", h);
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) begin
                valid = 1; op = 0; tag = base[31:12]; index = base[11:4]; offset = 4'(4 * i);
                void'(model_access(base + 32'(4 * i)));
            end else begin
                valid = 0;
            end
            @(negedge clk);
            if (i < 4) begin
                checks++;
                if (addr_ok !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_addr_ok %0d: addr_ok=%b, required 1", i, addr_ok);
                end
            end
            checks++;
            if (i == 0) begin
                if (data_ok !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_first_idle: data_ok=%b, required 0", data_ok);
                end
            end else if (data_ok !== 1'b1 || rdata !== mem_word(base + 32'(4 * (i - 1)))) begin
                errors++;
                $display("FAIL b2b_data %0d: data_ok=%b rdata=%h, required 1 %h",
                         i - 1, data_ok, rdata, mem_word(base + 32'(4 * (i - 1))));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lru();
        logic [31:0] seq [6];
        bit          exp_h [6];
        bit          h;
        seq = '{32'h0000A050, 32'h0000B050, 32'h0000A054, 32'h0000C058, 32'h0000A05C, 32'h0000B050};
        exp_h = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            do_read(seq[i], i % 3, -1, "lru", h);
            checks++;
            if (h !== exp_h[i]) begin
                errors++;
                $display("FAIL lru_step %0d addr=%h: hit=%b, required %b", i, seq[i], h, exp_h[i]);
            end
        end
    endtask

    task automatic test_reset_mid_refill();
        bit h;
        do_read(32'h20000040, 1, 2, "abort", h);
        do_read(32'h20000040, 0, -1, "after_abort", h);
        checks++;
        if (h !== 1'b0) begin
            errors++;
            $display("FAIL after_abort_kind: hit=%b, required 0", h);
        end
    endtask

    task automatic test_op_ignored();
        valid = 1; op = 1; tag = 20'hBFC00; index = 8'h00; offset = 4'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (addr_ok !== 1'b0 || data_ok !== 1'b0 || rd_req !== 1'b0) begin
                errors++;
                $display("FAIL op_ignored %0d: addr_ok=%b data_ok=%b rd_req=%b, required 0 0 0",
                         i, addr_ok, data_ok, rd_req);
            end
            @(posedge clk); #1;
        end
        valid = 0; op = 0;
    endtask

    task automatic test_random();
        logic [19:0] tags [4];
        logic [7:0]  sets [3];
        logic [31:0] a;
        bit          h;
        tags = '{20'h00001, 20'h12345, 20'hABCDE, 20'hFFFFF};
        sets = '{8'h03, 8'h04, 8'hC8};
        for (int i = 0; i < 150; i++) begin
            a = {tags[$urandom_range(0, 3)], sets[$urandom_range(0, 2)], 4'($urandom_range(0, 15))};
            do_read(a, int'($urandom_range(0, 3)), -1, "random", h);
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss_hit();
        test_critical_word();
        test_back_to_back();
        test_lru();
        test_reset_mid_refill();
        test_op_ignored();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/icache_2way.md
Name: icache_2way

Overview:
- Instruction cache that responds to the fetch stage's cache request interface: `valid`, `op`, `index`, `tag`, `offset`, `addr_ok`, `data_ok` and `rdata`.
- Read-only, 2-way set-associative, 16-byte lines (4 words), per-set LRU.
- Misses refill a whole line through a burst read port on the memory side, which the AXI bridge serves.
- Sits between the IF stage and the AXI bridge inside mycpu_top.

Parameters:
INDEX_WIDTH, 8, set index bits; number of sets = 2^INDEX_WIDTH
TAG_WIDTH, 20, tag bits; TAG_WIDTH + INDEX_WIDTH + 4 must equal 32

Ports:
clk  input  1  clock; all state updates on the rising edge
resetn  input  1  asynchronous, active-low reset
valid  input  1  fetch request valid
op  input  1  0 = read; 1 is illegal for this cache and is ignored (never accepted)
index  input  INDEX_WIDTH  set index, addr[11:4]
tag  input  TAG_WIDTH  physical tag, addr[31:12]
offset  input  4  byte offset in line; offset[3:2] selects the word
addr_ok  output  1  request accepted this cycle (valid & addr_ok)
data_ok  output  1  rdata valid this cycle; one pulse per accepted request, in order
rdata  output  32  instruction word
rd_req  output  1  line refill request
rd_type  output  3  fixed 3'b100 (whole line)
rd_addr  output  32  {tag, index, 4'b0000}
rd_rdy  input  1  memory side accepts rd_req
ret_valid  input  1  refill beat valid
ret_last  input  1  final refill beat
ret_data  input  32  refill word, ascending word order 0..3

Behaviour:
- Storage, per way and per set: valid bit, TAG_WIDTH tag, 4x32 data. One LRU bit per set.
- Reset (resetn=0, asynchronous):
  - All valid bits and LRU bits cleared; FSM goes to IDLE; refill beat counter cleared.
  - Outputs: `addr_ok`=1 (IDLE), `data_ok`=0, `rdata`=0, `rd_req`=0, `rd_addr`=0.
  - Tag and data arrays are not reset.
  - Reset mid-refill abandons the line; no array write occurs.
- FSM states: IDLE, LOOKUP, MISS, REFILL, RESPOND.
- IDLE:
  - `addr_ok`=1.
  - On valid & ~op: latch {tag, index, offset} into the request buffer, then go to LOOKUP.
- LOOKUP (compares the buffered tag against both ways of the buffered set):
  - Hit:
    - `data_ok`=1, `rdata` = the hit way's word at offset[3:2].
    - LRU[set] is set to point at the other way.
    - `addr_ok`=1. If valid & ~op, latch the new request and stay in LOOKUP; otherwise go to IDLE.
  - Miss:
    - `data_ok`=0, `addr_ok`=0; go to MISS.
    - Select the victim way: the first invalid way (way0 before way1); if both are valid, the way LRU[set] points at. Latch the victim.
- MISS:
  - `rd_req`=1, `rd_addr` = {buffered tag, buffered index, 4'b0}, `rd_type`=3'b100.
  - Hold all three stable until rd_rdy=1, then go to REFILL.
- REFILL:
  - Each ret_valid beat writes ret_data into line buffer word[cnt]; cnt increments by 1 (2 bits).
  - The beat where cnt == offset[3:2] is also captured into the response register.
  - On ret_valid & ret_last: write the line buffer (including the current beat) into the victim way, set its valid bit, write its tag, and set LRU to point at the other way. Go to RESPOND.
  - ret_last together with cnt != 3 is a protocol error: the line is still written, with unwritten words left undefined.
- RESPOND:
  - `data_ok`=1 and `rdata` = captured word for exactly one cycle; `addr_ok`=0; go to IDLE.
- Latency:
  - Hit: `data_ok` in the cycle after the accepting `addr_ok`.
  - Miss: 1 (LOOKUP) + rd_rdy wait + 4 beats + 1 (RESPOND).
- Throughput: back-to-back hits sustain 1 request/cycle.
- `rdata` holds its last value when `data_ok`=0.
- Requests with op=1 are never acknowledged (`addr_ok` is gated by ~op).
- ret_valid outside REFILL is ignored.
- Simultaneous hit-in-LOOKUP and new request on the same set: the new lookup sees the LRU update from this cycle.

Optional Feature:
ICACHE_PERF_CNT_EN:
- Defined: adds outputs `hit_cnt` [31:0] and `miss_cnt` [31:0].
  - `hit_cnt` increments on every LOOKUP hit; `miss_cnt` increments on every LOOKUP miss.
  - Both wrap at 2^32 and are cleared by resetn.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Cold miss, then hit:
   - Read 0xBFC00000; memory returns 0x11,0x22,0x33,0x44 with rd_rdy after 2 cycles.
   - Required: `rd_addr`=0xBFC00000, one `data_ok` with `rdata`=0x11.
   - Then read 0xBFC00008: `data_ok` next cycle with `rdata`=0x33 and no `rd_req`.
2. Critical-word capture: miss on 0x1000000C -> `rdata`=4th beat value, `data_ok` exactly one cycle after the ret_last cycle.
3. Back-to-back hits:
   - After filling line 0x00400000, drive valid for 4 consecutive cycles at offsets 0,4,8,C.
   - Required: `addr_ok`=1 each cycle and 4 consecutive `data_ok` pulses in order.
4. LRU replacement:
   - Fill tags A and B into set 5, hit A, then miss tag C in set 5 -> C replaces B.
   - A re-access of A hits; a re-access of B misses.
5. Reset mid-refill:
   - Assert resetn=0 after beat 2 of a refill -> `rd_req`=0, `data_ok`=0, state IDLE.
   - After release, re-reading the same address misses again.
6. With ICACHE_PERF_CNT_EN: after scenario 1, `hit_cnt`=1 and `miss_cnt`=1.
